// File: rtl/mem_datos_arbiter.sv
`default_nettype none
// ============================================================================
//  Module      : mem_datos_arbiter
//  Description : Two-port request/grant arbiter and access sequencer in front
//                of the 64-word data memory (Mem_datos). Port 0 (CPU
//                load/store) and port 1 (debug/loader) share the memory under
//                round-robin priority. Every access takes three cycles
//                (IDLE -> ACCESS -> RESP), and the memory's level-sensitive
//                EnW/EnR strobes are held for exactly the one ACCESS cycle.
//  Revision    : 1.0 - initial release
// ----------------------------------------------------------------------------
//  Ports
//    clk, reset           : clock (rising edge), synchronous active-high reset
//    reqN/weN/addrN/wdataN: port N request, held until gntN
//    gntN                 : port N grant pulse (high during the ACCESS cycle)
//    ackN                 : port N completion pulse (high during RESP)
//    rdataN               : port N read data, valid with ackN, held after
//    errN                 : port N address out of range, valid with ackN
//    mem_addr/mem_wdata   : memory Address / writeData
//    mem_enw/mem_enr      : memory EnW / EnR strobes
//    mem_rdata            : memory dataOutput
// ============================================================================
module mem_datos_arbiter #(
    parameter int DATA_W = 32,
    parameter int ADDR_W = 32,
    parameter int DEPTH  = 64
) (
    input  logic              clk,
    input  logic              reset,

    input  logic              req0,
    input  logic              we0,
    input  logic [ADDR_W-1:0] addr0,
    input  logic [DATA_W-1:0] wdata0,
    output logic              gnt0,
    output logic              ack0,
    output logic [DATA_W-1:0] rdata0,
    output logic              err0,

    input  logic              req1,
    input  logic              we1,
    input  logic [ADDR_W-1:0] addr1,
    input  logic [DATA_W-1:0] wdata1,
    output logic              gnt1,
    output logic              ack1,
    output logic [DATA_W-1:0] rdata1,
    output logic              err1,

    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    output logic              mem_enw,
    output logic              mem_enr,
    input  logic [DATA_W-1:0] mem_rdata
);

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_ACCESS = 2'd1,
        S_RESP   = 2'd2
    } state_t;

    localparam logic [ADDR_W-1:0] c_DEPTH = ADDR_W'(DEPTH);

    state_t r_state;
    logic   r_prio;      // port that wins when both request (not granted last)
    logic   r_id;        // port owning the current transaction
    logic   r_we;        // latched direction of the current transaction
    logic   r_in_range;  // latched address check of the current transaction

    logic              w_win;
    logic              w_any;
    logic              w_win_we;
    logic [ADDR_W-1:0] w_win_addr;
    logic [DATA_W-1:0] w_win_wdata;
    logic              w_win_in_range;

    // Winner selection: a lone requester wins outright; on contention the
    // pointer decides.
    always_comb begin
        w_any          = req0 | req1;
        w_win          = (req0 & req1) ? r_prio : req1;
        w_win_we       = w_win ? we1    : we0;
        w_win_addr     = w_win ? addr1  : addr0;
        w_win_wdata    = w_win ? wdata1 : wdata0;
        // Full-width unsigned compare so high address bits are never ignored.
        w_win_in_range = (w_win_addr < c_DEPTH);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state    <= S_IDLE;
            r_prio     <= 1'b0;
            r_id       <= 1'b0;
            r_we       <= 1'b0;
            r_in_range <= 1'b0;
            gnt0       <= 1'b0;
            gnt1       <= 1'b0;
            ack0       <= 1'b0;
            ack1       <= 1'b0;
            err0       <= 1'b0;
            err1       <= 1'b0;
            rdata0     <= '0;
            rdata1     <= '0;
            mem_addr   <= '0;
            mem_wdata  <= '0;
            mem_enw    <= 1'b0;
            mem_enr    <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (w_any) begin
                        r_id       <= w_win;
                        r_we       <= w_win_we;
                        r_in_range <= w_win_in_range;
                        r_prio     <= ~w_win;
                        gnt0       <= ~w_win;
                        gnt1       <= w_win;
                        // Memory drive is loaded here so that it is purely
                        // registered for the single ACCESS cycle.
                        mem_addr   <= w_win_addr;
                        mem_wdata  <= w_win_wdata;
                        mem_enw    <= w_win_we & w_win_in_range;
                        mem_enr    <= ~w_win_we & w_win_in_range;
                        r_state    <= S_ACCESS;
                    end
                end

                S_ACCESS: begin
                    gnt0      <= 1'b0;
                    gnt1      <= 1'b0;
                    mem_addr  <= '0;
                    mem_wdata <= '0;
                    mem_enw   <= 1'b0;
                    mem_enr   <= 1'b0;
                    // Read data is only replaced by a read; a write ack leaves
                    // the previously returned word in place.
                    if (!r_id) begin
                        ack0 <= 1'b1;
                        err0 <= ~r_in_range;
                        if (!r_we) begin
                            rdata0 <= r_in_range ? mem_rdata : '0;
                        end
                    end else begin
                        ack1 <= 1'b1;
                        err1 <= ~r_in_range;
                        if (!r_we) begin
                            rdata1 <= r_in_range ? mem_rdata : '0;
                        end
                    end
                    r_state <= S_RESP;
                end

                S_RESP: begin
                    ack0    <= 1'b0;
                    ack1    <= 1'b0;
                    err0    <= 1'b0;
                    err1    <= 1'b0;
                    r_state <= S_IDLE;
                end

                default: begin
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_mem_datos_arbiter.sv
`default_nettype none
// ============================================================================
//  Module      : tb_mem_datos_arbiter
//  Description : Self-checking bench for mem_datos_arbiter. A behavioural
//                memory stands in for Mem_datos; a transaction-level reference
//                (expected memory contents, round-robin winner, three-cycle
//                access cadence) predicts every grant, ack, error and read.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_mem_datos_arbiter;

    typedef struct packed {
        logic        we;
        logic [31:0] addr;
        logic [31:0] data;
    } op_t;

    logic        clk = 1'b0;
    logic        reset;
    logic        req0, we0, gnt0, ack0, err0;
    logic [31:0] addr0, wdata0, rdata0;
    logic        req1, we1, gnt1, ack1, err1;
    logic [31:0] addr1, wdata1, rdata1;
    logic [31:0] mem_addr, mem_wdata, mem_rdata;
    logic        mem_enw, mem_enr;

    mem_datos_arbiter #(.DATA_W(32), .ADDR_W(32), .DEPTH(64)) dut (
        .clk(clk), .reset(reset),
        .req0(req0), .we0(we0), .addr0(addr0), .wdata0(wdata0),
        .gnt0(gnt0), .ack0(ack0), .rdata0(rdata0), .err0(err0),
        .req1(req1), .we1(we1), .addr1(addr1), .wdata1(wdata1),
        .gnt1(gnt1), .ack1(ack1), .rdata1(rdata1), .err1(err1),
        .mem_addr(mem_addr), .mem_wdata(mem_wdata),
        .mem_enw(mem_enw), .mem_enr(mem_enr), .mem_rdata(mem_rdata)
    );

    always #5 clk = ~clk;

    // Behavioural Mem_datos: decodes only the low 6 address bits, so any
    // strobe on an out-of-range address would alias onto a real word.
    logic [31:0] env_mem [0:63] = '{default: '0};
    always @(posedge clk) begin
        if (mem_enw) env_mem[mem_addr[5:0]] <= mem_wdata;
    end
    assign mem_rdata = mem_enr ? env_mem[mem_addr[5:0]] : 32'hBAD0_BAD0;

    // Reference state
    logic [31:0] ref_mem [0:63];
    logic [31:0] exp_rd [0:1];
    op_t         q0[$];
    op_t         q1[$];
    op_t         cur0, cur1, fl_op;
    logic        fl_port, prio, adv0, adv1;
    int          since, gcnt0, gcnt1;
    int          n_pass = 0;
    int          n_fail = 0;
    int          n_total = 0;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_total++;
        assert (obs === exp) n_pass++;
        else begin
            n_fail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Present the next queued op on a port once its previous one was granted.
    task automatic drive();
        if (adv0 || !req0) begin
            if (q0.size() > 0) begin cur0 = q0.pop_front(); req0 = 1'b1; end
            else req0 = 1'b0;
        end
        if (adv1 || !req1) begin
            if (q1.size() > 0) begin cur1 = q1.pop_front(); req1 = 1'b1; end
            else req1 = 1'b0;
        end
        adv0 = 1'b0; adv1 = 1'b0;
        we0 = cur0.we; addr0 = cur0.addr; wdata0 = cur0.data;
        we1 = cur1.we; addr1 = cur1.addr; wdata1 = cur1.data;
    endtask

    // One clock: predict and check every output, then update the stimulus.
    task automatic step();
        logic pr0, pr1, eg0, eg1, ea0, ea1, ee0, ee1, win, inr;
        op_t  gop;
        pr0 = req0; pr1 = req1;
        eg0 = 0; eg1 = 0; ea0 = 0; ea1 = 0; ee0 = 0; ee1 = 0;
        @(posedge clk); #1;
        chk("enw_and_enr", mem_enw & mem_enr, 0);
        chk("strobe_outside_access", (mem_enw | mem_enr) & ~(gnt0 | gnt1), 0);
        chk("gnt_both", gnt0 & gnt1, 0);
        chk("ack_both", ack0 & ack1, 0);
        // Completion lands the cycle after the grant.
        if (since == 0) begin
            inr = (fl_op.addr < 32'd64);
            if (fl_port) begin ea1 = 1; ee1 = !inr; end
            else         begin ea0 = 1; ee0 = !inr; end
            if (fl_op.we) begin
                if (inr) ref_mem[fl_op.addr[5:0]] = fl_op.data;
            end else begin
                exp_rd[fl_port] = inr ? ref_mem[fl_op.addr[5:0]] : 32'h0;
            end
        end
        // A new grant needs the arbiter free (two cycles after the last grant)
        // and a request visible at the edge.
        if (since >= 2 && (pr0 || pr1)) begin
            win = (pr0 && pr1) ? prio : pr1;
            gop = win ? cur1 : cur0;
            inr = (gop.addr < 32'd64);
            if (win) begin eg1 = 1; gcnt1++; adv1 = 1; end
            else     begin eg0 = 1; gcnt0++; adv0 = 1; end
            chk("mem_addr", mem_addr, gop.addr);
            chk("mem_wdata", mem_wdata, gop.data);
            chk("mem_enw", mem_enw, gop.we & inr);
            chk("mem_enr", mem_enr, !gop.we & inr);
            fl_op = gop; fl_port = win; prio = !win; since = 0;
        end else if (since < 2) begin
            since++;
        end
        chk("gnt0", gnt0, eg0);
        chk("gnt1", gnt1, eg1);
        chk("ack0", ack0, ea0);
        chk("ack1", ack1, ea1);
        chk("err0", err0, ee0);
        chk("err1", err1, ee1);
        chk("rdata0", rdata0, exp_rd[0]);
        chk("rdata1", rdata1, exp_rd[1]);
        drive();
    endtask

    task automatic run(input int budget);
        int n;
        n = 0;
        while (!(q0.size() == 0 && q1.size() == 0 && !req0 && !req1 && since >= 2)
               && n < budget) begin
            step();
            n++;
        end
        chk("run_complete", (q0.size() == 0 && q1.size() == 0 && since >= 2), 1);
    endtask

    task automatic reset_dut();
        reset = 1'b1; req0 = 1'b0; req1 = 1'b0; adv0 = 1'b0; adv1 = 1'b0;
        q0.delete(); q1.delete();
        @(posedge clk); #1;
        chk("rst_gnt0", gnt0, 0);       chk("rst_gnt1", gnt1, 0);
        chk("rst_ack0", ack0, 0);       chk("rst_ack1", ack1, 0);
        chk("rst_err0", err0, 0);       chk("rst_err1", err1, 0);
        chk("rst_rdata0", rdata0, 0);   chk("rst_rdata1", rdata1, 0);
        chk("rst_mem_addr", mem_addr, 0);
        chk("rst_mem_wdata", mem_wdata, 0);
        chk("rst_mem_enw", mem_enw, 0); chk("rst_mem_enr", mem_enr, 0);
        reset = 1'b0;
        since = 2; prio = 1'b0; gcnt0 = 0; gcnt1 = 0;
        exp_rd[0] = '0; exp_rd[1] = '0;
    endtask

    initial begin
        op_t o;
        reset = 1'b1;
        req0 = 0; we0 = 0; addr0 = '0; wdata0 = '0;
        req1 = 0; we1 = 0; addr1 = '0; wdata1 = '0;
        cur0 = '0; cur1 = '0; fl_op = '0; fl_port = 0;
        for (int i = 0; i < 64; i++) ref_mem[i] = '0;

        // 1: port 0 write then read back address 5
        reset_dut();
        q0.push_back('{we: 1'b1, addr: 32'd5, data: 32'hDEADBEEF});
        q0.push_back('{we: 1'b0, addr: 32'd5, data: 32'h0});
        drive();
        run(20);
        chk("t1_rdata0", rdata0, 32'hDEADBEEF);
        chk("t1_err0", err0, 0);

        // 2: both ports held continuously, distinct address ranges
        reset_dut();
        for (int i = 0; i < 8; i++) begin
            q0.push_back('{we: 1'b1, addr: 32'(i), data: $urandom});
            q1.push_back('{we: 1'b1, addr: 32'(32 + i), data: $urandom});
        end
        for (int i = 0; i < 8; i++) begin
            q0.push_back('{we: 1'b0, addr: 32'(i), data: 32'h0});
            q1.push_back('{we: 1'b0, addr: 32'(32 + i), data: 32'h0});
        end
        drive();
        run(120);
        chk("t2_grants0", gcnt0, 16);
        chk("t2_grants1", gcnt1, 16);

        // Randomized mixed traffic, including out-of-range addresses
        for (int i = 0; i < 24; i++) begin
            o.we = 1'($urandom_range(0, 1)); o.addr = 32'($urandom_range(0, 79)); o.data = $urandom;
            q0.push_back(o);
            o.we = 1'($urandom_range(0, 1)); o.addr = 32'($urandom_range(0, 79)); o.data = $urandom;
            q1.push_back(o);
        end
        drive();
        run(200);

        // 3: out-of-range accesses on port 1, incl. ones aliasing word 0
        q1.push_back('{we: 1'b1, addr: 32'd64, data: 32'h12345678});
        q1.push_back('{we: 1'b0, addr: 32'd100, data: 32'h0});
        q1.push_back('{we: 1'b1, addr: 32'hFFFF_FFC0, data: 32'hA5A5A5A5});
        q1.push_back('{we: 1'b0, addr: 32'h0000_0140, data: 32'h0});
        drive();
        run(20);
        chk("t3_mem_word0", env_mem[0], ref_mem[0]);
        chk("t3_rdata1", rdata1, 0);

        // 4: reset during the ACCESS cycle of a port 0 read
        q0.push_back('{we: 1'b0, addr: 32'd33, data: 32'h0});
        drive();
        step();
        chk("t4_in_access", gnt0, 1);
        reset_dut();
        q1.push_back('{we: 1'b0, addr: 32'd5, data: 32'h0});
        drive();
        step();
        chk("t4_gnt1_latency", gnt1, 1);
        run(20);
        chk("t4_no_port0_grant", gcnt0, 0);

        // 5: only port 1 requesting for nine cycles
        reset_dut();
        for (int i = 0; i < 3; i++)
            q1.push_back('{we: 1'b0, addr: 32'(i * 7), data: 32'h0});
        drive();
        for (int i = 0; i < 9; i++) step();
        chk("t5_grants1", gcnt1, 3);
        chk("t5_grants0", gcnt0, 0);
        run(10);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
`default_nettype wire
